// File: rtl/frame_sequencer_if.sv
// Bit-stream input and field-strobe output bundle of the frame sequencer.
interface frame_sequencer_if;
   logic       enable;
   logic       bit_valid;
   logic       bit_value;
   logic       shift_en;
   logic       shift_bit;
   logic [2:0] field_idx;
   logic       field_done;
   logic       frame_done;
   logic       frame_error;
   logic       busy;

   modport master (
      output enable, bit_valid, bit_value,
      input  shift_en, shift_bit, field_idx, field_done, frame_done, frame_error, busy
   );

   modport slave (
      input  enable, bit_valid, bit_value,
      output shift_en, shift_bit, field_idx, field_done, frame_done, frame_error, busy
   );
endinterface

// File: rtl/frame_sequencer.sv
// Hunts a 32-bit preamble in the decoded bit stream, then steers 160 payload bits into field registers.
// One cycle from bit strobe to shift strobe; no backpressure, a truncated frame is dropped on timeout.
module frame_sequencer #(
   parameter logic [31:0] PREAMBLE       = 32'hA5A5_5A5A,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter int          CNT_W          = 11
) (
   input logic              clock_i,
   input logic              reset_i,
   frame_sequencer_if.slave sif_io
);

   typedef enum logic {HUNT, PAYLOAD} state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       LAST_BIT = 8'd159;
   localparam logic [5:0]       FULL     = 6'd32;

   state_t           state_q, state_d;
   logic [31:0]      window_q, window_d;
   logic [5:0]       fill_q, fill_d;
   logic [7:0]       pay_cnt_q, pay_cnt_d;
   logic [4:0]       fld_bit_q, fld_bit_d;
   logic [2:0]       cur_fld_q, cur_fld_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;

   logic             shift_en_q, shift_en_d;
   logic             shift_bit_q, shift_bit_d;
   logic [2:0]       field_idx_q, field_idx_d;
   logic             field_done_q, field_done_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_error_q, frame_error_d;
   logic             busy_q, busy_d;

   logic [31:0]      win_shift;
   logic [5:0]       fill_inc;
   logic             go_hunt;

   function automatic logic [4:0] fld_last(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd4, 3'd5: fld_last = 5'd15;
         3'd2, 3'd3:             fld_last = 5'd31;
         3'd6:                   fld_last = 5'd7;
         default:                fld_last = 5'd23;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      window_d      = window_q;
      fill_d        = fill_q;
      pay_cnt_d     = pay_cnt_q;
      fld_bit_d     = fld_bit_q;
      cur_fld_d     = cur_fld_q;
      tmo_d         = tmo_q;
      shift_en_d    = 1'b0;
      shift_bit_d   = 1'b0;
      field_idx_d   = field_idx_q;
      field_done_d  = 1'b0;
      frame_done_d  = 1'b0;
      frame_error_d = 1'b0;
      go_hunt       = 1'b0;
      win_shift     = {window_q[30:0], sif_io.bit_value};
      fill_inc      = (fill_q == FULL) ? FULL : fill_q + 6'd1;

      unique case (state_q)
         HUNT: begin
            field_idx_d = '0;
            tmo_d       = '0;
            if (sif_io.enable && sif_io.bit_valid) begin
               window_d = win_shift;
               fill_d   = fill_inc;
               if (win_shift == PREAMBLE && fill_inc == FULL) begin
                  state_d   = PAYLOAD;
                  pay_cnt_d = '0;
                  fld_bit_d = '0;
                  cur_fld_d = '0;
               end
            end
         end
         PAYLOAD: begin
            if (!sif_io.enable) begin
               frame_error_d = 1'b1;
               go_hunt       = 1'b1;
            end else if (sif_io.bit_valid) begin
               // A strobe landing on the timeout cycle still counts: the bit wins.
               shift_en_d  = 1'b1;
               shift_bit_d = sif_io.bit_value;
               field_idx_d = cur_fld_q;
               tmo_d       = '0;
               pay_cnt_d   = pay_cnt_q + 8'd1;
               if (fld_bit_q == fld_last(cur_fld_q)) begin
                  field_done_d = 1'b1;
                  fld_bit_d    = '0;
                  cur_fld_d    = cur_fld_q + 3'd1;
               end else begin
                  fld_bit_d = fld_bit_q + 5'd1;
               end
               if (pay_cnt_q == LAST_BIT) begin
                  frame_done_d = 1'b1;
                  go_hunt      = 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               frame_error_d = 1'b1;
               go_hunt       = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
            // Leaving PAYLOAD wipes the window so stale payload bits can never re-match.
            if (go_hunt) begin
               state_d   = HUNT;
               window_d  = '0;
               fill_d    = '0;
               pay_cnt_d = '0;
               fld_bit_d = '0;
               cur_fld_d = '0;
               tmo_d     = '0;
            end
         end
         default: state_d = HUNT;
      endcase

      busy_d = (state_q == PAYLOAD);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= HUNT;
         window_q      <= '0;
         fill_q        <= '0;
         pay_cnt_q     <= '0;
         fld_bit_q     <= '0;
         cur_fld_q     <= '0;
         tmo_q         <= '0;
         shift_en_q    <= 1'b0;
         shift_bit_q   <= 1'b0;
         field_idx_q   <= '0;
         field_done_q  <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         window_q      <= window_d;
         fill_q        <= fill_d;
         pay_cnt_q     <= pay_cnt_d;
         fld_bit_q     <= fld_bit_d;
         cur_fld_q     <= cur_fld_d;
         tmo_q         <= tmo_d;
         shift_en_q    <= shift_en_d;
         shift_bit_q   <= shift_bit_d;
         field_idx_q   <= field_idx_d;
         field_done_q  <= field_done_d;
         frame_done_q  <= frame_done_d;
         frame_error_q <= frame_error_d;
         busy_q        <= busy_d;
      end
   end

   assign sif_io.shift_en    = shift_en_q;
   assign sif_io.shift_bit   = shift_bit_q;
   assign sif_io.field_idx   = field_idx_q;
   assign sif_io.field_done  = field_done_q;
   assign sif_io.frame_done  = frame_done_q;
   assign sif_io.frame_error = frame_error_q;
   assign sif_io.busy        = busy_q;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Controls the thermostat-packet capture datapath.
- Consumes the decoded bit stream (one strobe per recovered Manchester bit) and hunts for the 32-bit preamble.
- Then counts the 160 payload bits and drives the shift/field-latch strobes that load the type_1, type_2, constant, thermostat_id, room_temp, set_temp, state and tail registers.
- Detects truncated frames by inter-bit timeout and recovers to preamble hunt.

Parameters:
- PREAMBLE, 32'hA5A5_5A5A, preamble bit pattern; the first-received bit sits in the MSB.
- TIMEOUT_CYCLES, 1024, maximum clock cycles between bit strobes while in PAYLOAD before the frame is aborted.
- CNT_W, 11, width of the timeout counter. It must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock, input, 1, system clock; all logic is on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, accept bits when high.
- bit_valid, input, 1, one-cycle strobe: a decoded bit is present.
- bit_value, input, 1, decoded bit; sampled only when bit_valid=1.
- shift_en, output, 1, one-cycle strobe: shift shift_bit into the field register selected by field_idx.
- shift_bit, output, 1, payload bit being shifted.
- field_idx, output, 3, current field: 0 type_1(16), 1 type_2(16), 2 constant(32), 3 thermostat_id(32), 4 room_temp(16), 5 set_temp(16), 6 state(8), 7 tail(24).
- field_done, output, 1, pulses with the last shift_en of a field; field_idx names that field.
- frame_done, output, 1, pulses with the final payload shift_en (bit 159).
- frame_error, output, 1, one-cycle pulse when a frame is aborted (timeout or enable drop).
- busy, output, 1, high while in PAYLOAD.

Behaviour:
- Synchronous reset, active high. Reset values:
  - state=HUNT
  - window=0, fill count=0, payload bit count=0, field bit count=0, timeout count=0
  - all outputs 0
- Reset mid-frame discards the frame silently; no frame_error is raised.
- All outputs are registered. Latency from bit_valid to shift_en is exactly 1 cycle.
- State HUNT:
  - On bit_valid & enable: window <= {window[30:0], bit_value}; fill saturates at 32.
  - If the new window equals PREAMBLE and the new fill equals 32, go to PAYLOAD next cycle, with payload count=0, field_idx=0, field bit=0, timeout=0.
  - Matching is sliding: any garbage prefix is tolerated.
  - No shift_en is issued for preamble bits.
- State PAYLOAD (busy=1):
  - On bit_valid & enable, next cycle: shift_en=1 and shift_bit=bit_value; payload count increments; timeout clears.
  - The field bit counter wraps at the field length (16/16/32/32/16/16/8/24), and field_idx then advances.
  - field_done=1 alongside the last bit of each field.
  - On bit 159: field_done=1 (field_idx=7) and frame_done=1 in the same cycle, and state returns to HUNT.
- Timeout in PAYLOAD:
  - The counter increments on every cycle without bit_valid.
  - When it reaches TIMEOUT_CYCLES: frame_error=1 for one cycle, go to HUNT, no frame_done.
  - If bit_valid coincides with the timeout-reaching cycle, the bit wins: the counter clears and the bit is accepted.
- enable=0:
  - bit_valid is ignored in all states.
  - If in PAYLOAD: frame_error pulse next cycle and go to HUNT.
  - If in HUNT: window and fill are held.
- Every entry to HUNT (done, error, reset) clears window and fill. This prevents re-matching on stale bits; back-to-back frames need a full fresh preamble.
- The timeout counter is not active in HUNT.
- field_idx holds its last value between strobes. It returns to 0 on HUNT entry.

Test Plan:
- Clean frame: PREAMBLE then 160 bits, with bit_valid every 8 cycles.
  - shift_en ×160, each 1 cycle after its strobe.
  - field_done at payload bits 15, 31, 63, 95, 111, 127, 135, 159 with field_idx 0–7.
  - frame_done coincident with bit 159; busy falls the next cycle.
- Garbage prefix: 13 random bits, then PREAMBLE, then payload.
  - Lock occurs only after the preamble's last bit; the frame completes identically.
  - A prefix forming a near-match (31 of 32 bits) does not lock.
- Timeout: preamble plus 40 payload bits, then silence.
  - frame_error exactly TIMEOUT_CYCLES (1024) cycles after the last strobe.
  - No frame_done; busy=0 afterwards.
  - A bit_valid on cycle 1024 instead keeps the frame alive.
- Enable drop: enable=0 at payload bit 70.
  - frame_error the next cycle, then HUNT.
  - Strobes while enable=0 produce no shift_en.
- Reset mid-frame: reset at payload bit 100.
  - All outputs 0 the following cycle; no frame_error.
  - A fresh preamble then locks normally.
- Back-to-back frames: two full frames with no gap.
  - Two frame_done pulses, 320 shift_en total.
  - Payload tail bits equal to PREAMBLE do not cause a spurious lock mid-payload.
